// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I/RV64I opcode, funct and immediate-format definitions shared by decode.
package riscv_pkg;

    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    localparam logic [2:0] F3_JALR     = 3'd0;
    localparam logic [2:0] F3_ADD_SUB  = 3'd0;
    localparam logic [2:0] F3_SLL      = 3'd1;
    localparam logic [2:0] F3_SR       = 3'd5;
    localparam logic [2:0] F3_BR_RSV2  = 3'd2;
    localparam logic [2:0] F3_BR_RSV3  = 3'd3;
    localparam logic [2:0] F3_LD       = 3'd3;
    localparam logic [2:0] F3_LWU      = 3'd6;
    localparam logic [2:0] F3_LOAD_RSV = 3'd7;
    localparam logic [2:0] F3_SD       = 3'd3;
    localparam logic [2:0] F3_FENCE    = 3'd0;
    localparam logic [2:0] F3_FENCE_I  = 3'd1;

    localparam logic [6:0] F7_BASE     = 7'h00;
    localparam logic [6:0] F7_ALT      = 7'h20;
    localparam logic [5:0] F6_BASE     = 6'h00;
    localparam logic [5:0] F6_ALT      = 6'h10;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_type_e;

    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic [4:0] addr1;
        logic [4:0] addr2;
        logic [4:0] addr_dest;
        logic       alu_sel;
        logic       rs1_en;
        logic       rs2_en;
        logic       rd_we;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - Combinational immediate extraction, sign-extended to XLEN.
module imm_gen
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr,
    input  imm_type_e       imm_type,
    output logic [XLEN-1:0] imm
);

    logic signed [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (imm_type)
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Signed cast replicates bit 31 into the upper half when XLEN = 64.
    assign imm = XLEN'(imm32);

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - Handshaked RV32I/RV64I decode stage with flush and illegal detection.
module decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [4:0]      out_addr1,
    output logic [4:0]      out_addr2,
    output logic [4:0]      out_addr_dest,
    output logic [XLEN-1:0] out_imm,
    output logic            alu_sel,
    output logic            out_rs1_en,
    output logic            out_rs2_en,
    output logic            out_rd_we,
    output logic            out_illegal
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign funct3 = in_instr[14:12];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign funct7 = in_instr[31:25];

    dec_t            dec;
    imm_type_e       imm_type;
    logic [XLEN-1:0] imm;
    logic            legal;
    logic            shift_ok;
    logic            use_rd;
    logic            use_rs1;
    logic            use_rs2;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr    (in_instr[31:7]),
        .imm_type (imm_type),
        .imm      (imm)
    );

    // RV64 shamt is 6 bits, so only instr[31:26] carries the shift kind.
    always_comb begin
        shift_ok = 1'b0;
        if (funct3 == F3_SLL) begin
            shift_ok = (XLEN == 32) ? (funct7 == F7_BASE) : (in_instr[31:26] == F6_BASE);
        end else begin
            shift_ok = (XLEN == 32) ? (funct7 == F7_BASE || funct7 == F7_ALT)
                                    : (in_instr[31:26] == F6_BASE || in_instr[31:26] == F6_ALT);
        end
    end

    always_comb begin
        dec        = '0;
        imm_type   = IMM_NONE;
        legal      = 1'b1;
        use_rd     = 1'b0;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        dec.opcode = opcode;
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                use_rd      = 1'b1;
                imm_type    = IMM_U;
                dec.alu_sel = 1'b1;
            end
            OP_JAL: begin
                use_rd   = 1'b1;
                imm_type = IMM_J;
            end
            OP_JALR: begin
                use_rd      = 1'b1;
                use_rs1     = 1'b1;
                dec.funct3  = funct3;
                imm_type    = IMM_I;
                dec.alu_sel = 1'b1;
                legal       = (funct3 == F3_JALR);
            end
            OP_BRANCH: begin
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
                dec.funct3 = funct3;
                imm_type   = IMM_B;
                legal      = !(funct3 == F3_BR_RSV2 || funct3 == F3_BR_RSV3);
            end
            OP_LOAD: begin
                use_rd      = 1'b1;
                use_rs1     = 1'b1;
                dec.funct3  = funct3;
                imm_type    = IMM_I;
                dec.alu_sel = 1'b1;
                legal       = !(funct3 == F3_LOAD_RSV ||
                                (XLEN == 32 && (funct3 == F3_LD || funct3 == F3_LWU)));
            end
            OP_STORE: begin
                use_rs1     = 1'b1;
                use_rs2     = 1'b1;
                dec.funct3  = funct3;
                imm_type    = IMM_S;
                dec.alu_sel = 1'b1;
                legal       = !funct3[2] && !(XLEN == 32 && funct3 == F3_SD);
            end
            OP_IMM: begin
                use_rd      = 1'b1;
                use_rs1     = 1'b1;
                dec.funct3  = funct3;
                imm_type    = IMM_I;
                dec.alu_sel = 1'b1;
                if (funct3 == F3_SLL || funct3 == F3_SR) begin
                    dec.funct7 = funct7;
                    legal      = shift_ok;
                end
            end
            OP_OP: begin
                use_rd     = 1'b1;
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
                dec.funct3 = funct3;
                dec.funct7 = funct7;
                legal      = (funct7 == F7_BASE) ||
                             (funct7 == F7_ALT && (funct3 == F3_ADD_SUB || funct3 == F3_SR));
            end
            OP_MISC_MEM: begin
                dec.funct3 = funct3;
                legal      = (funct3 == F3_FENCE || funct3 == F3_FENCE_I);
            end
            OP_SYSTEM: begin
                legal = (in_instr == INSTR_ECALL || in_instr == INSTR_EBREAK);
            end
            // Also catches every encoding with instr[1:0] != 2'b11.
            default: legal = 1'b0;
        endcase

        if (use_rd) begin
            dec.addr_dest = rd;
            dec.rd_we     = (rd != 5'd0);
        end
        if (use_rs1) begin
            dec.addr1  = rs1;
            dec.rs1_en = 1'b1;
        end
        if (use_rs2) begin
            dec.addr2  = rs2;
            dec.rs2_en = 1'b1;
        end

        if (!legal) begin
            dec         = '0;
            dec.opcode  = opcode;
            dec.illegal = 1'b1;
            imm_type    = IMM_NONE;
        end
    end

    logic            valid_d, valid_q;
    dec_t            dec_d, dec_q;
    logic [XLEN-1:0] imm_d, imm_q;
    logic [XLEN-1:0] pc_d, pc_q;
    logic            accept;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        dec_d   = dec_q;
        imm_d   = imm_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            dec_d   = dec;
            imm_d   = imm;
            pc_d    = in_pc;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            dec_q   <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            dec_q   <= dec_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_pc        = pc_q;
    assign out_imm       = imm_q;
    assign out_opcode    = dec_q.opcode;
    assign out_funct3    = dec_q.funct3;
    assign out_funct7    = dec_q.funct7;
    assign out_addr1     = dec_q.addr1;
    assign out_addr2     = dec_q.addr2;
    assign out_addr_dest = dec_q.addr_dest;
    assign alu_sel       = dec_q.alu_sel;
    assign out_rs1_en    = dec_q.rs1_en;
    assign out_rs2_en    = dec_q.rs2_en;
    assign out_rd_we     = dec_q.rd_we;
    assign out_illegal   = dec_q.illegal;

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised, handshaked RV32I/RV64I instruction-decode pipeline stage. It sits between fetch and register-read/execute. Each cycle it accepts one fetched instruction and its PC over a valid/ready interface and registers the decoded fields, the sign-extended immediate (XLEN wide) and the control flags. Over the previous decode generation it adds back-pressure, flush, register-enable flags and illegal-instruction detection.

## Interface
- XLEN, 32, datapath/immediate/PC width; legal values 32 or 64
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  kill held and incoming instruction
- in_valid  in  1  fetch offers instruction
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction word
- in_pc  in  XLEN  PC of in_instr
- out_valid  out  1  decoded instruction held
- out_ready  in  1  downstream accepts
- out_pc  out  XLEN  registered PC
- out_opcode  out  7  instr[6:0]
- out_funct3  out  3  funct3, or 0 where the format has none
- out_funct7  out  7  funct7 for OP and shift-immediates, else 0
- out_addr1, out_addr2, out_addr_dest  out  5 each  rs1/rs2/rd, or 0 if unused
- out_imm  out  XLEN  sign-extended immediate (U-type: sign-extended from bit 31)
- alu_sel  out  1  1 = ALU operand B is the immediate (OP_IMM, LOAD, STORE, JALR, AUIPC, LUI)
- out_rs1_en, out_rs2_en  out  1 each  source register is read
- out_rd_we  out  1  destination written (0 when rd == x0)
- out_illegal  out  1  instruction is illegal

## Operation
- Handshake: in_ready = !out_valid || out_ready. An accept occurs when in_valid && in_ready.
- Priority per cycle: rst > flush > accept > drain.
- rst: out_valid = 0 and every output register = 0.
- flush: out_valid becomes 0 next cycle. An instruction offered in the same cycle is consumed and dropped.
- Accept: all output registers load the decode of in_instr/in_pc; out_valid = 1.
- Drain: no accept and out_ready = 1, so out_valid becomes 0. Data registers hold their values.
- Hold: out_valid && !out_ready, so all outputs stay bit-stable.
- Decoded opcodes:
  - LUI, AUIPC, JAL, JALR, LOAD, STORE, BRANCH, OP_IMM, OP
  - MISC_MEM: funct3 0 or 1, no register effects
  - SYSTEM: only ECALL 0x00000073 and EBREAK 0x00100073; all CSR forms are illegal
- Illegal when any of these holds:
  - instr[1:0] != 2'b11, or unknown opcode
  - JALR with funct3 != 0
  - BRANCH with funct3 2 or 3
  - LOAD with funct3 7; funct3 3 or 6 when XLEN = 32
  - STORE with funct3 ≥ 4; funct3 3 when XLEN = 32
  - OP with funct7 ∉ {0x00, 0x20}, or 0x20 with funct3 ∉ {0, 5}
  - OP_IMM shift with illegal upper bits: instr[31:25] must be 0x00 or 0x20 (SRAI only) when XLEN = 32; instr[31:26] must be 0x00 or 0x10 when XLEN = 64
- Illegal instruction output: out_illegal = 1, out_opcode = raw instr[6:0], out_pc kept, all other fields and flags 0.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 instruction/cycle with out_ready held high.
- in_ready is combinational from out_valid and out_ready only; no path from in_valid or flush.
- All outputs except in_ready are registered.
- Reset value of every output register is 0, including out_valid. in_ready reads 1 in the cycle after reset.

## Structure
- Shared package riscv_pkg holds:
  - the opcode constants (OP_LUI … OP_SYSTEM, OP_MISC_MEM)
  - the funct3/funct7 constants
  - the ECALL/EBREAK encodings
  - the imm-type enum {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE}
- One combinational sub-module, imm_gen (instr, imm_type -> XLEN-bit immediate), instantiated once.
- The legality and flag decode stays in decode_stage.

## Test plan
- addi x1,x2,-1 (0xFFF10093), XLEN = 32 -> out_opcode = 0x13, rd = 1, rs1 = 2, out_imm = 0xFFFFFFFF, alu_sel = 1, rd_we = 1, rs2_en = 0; out_valid one cycle after accept.
- lui x5,0x12345 (0x123452B7) -> out_imm = 0x12345000, rs1_en = 0. beq x1,x2,-4 (0xFE208EE3) -> out_imm = 0xFFFFFFFC, rd_we = 0, rs1_en = rs2_en = 1.
- Back-to-back stream of 8 instructions with out_ready = 0 for cycles 3–4 -> in_ready = 0 for those cycles, outputs stable, no instruction lost or duplicated.
- 0x00000000, 0x00002073 (csrrs) and sub with funct3 = 1 -> out_illegal = 1, all other flags 0.
- flush asserted with out_valid = 1 and in_valid = 1 -> next cycle out_valid = 0 and the offered instruction never appears. rst asserted mid-stream -> all outputs 0 on the next edge.
- XLEN = 64: addi -1 -> out_imm = 0xFFFFFFFFFFFFFFFF; ld (funct3 = 3) is legal; the same word with XLEN = 32 -> out_illegal = 1.
